// File: rtl/fifo_1r1w_sync_read.sv
// Single-clock FIFO with a block-RAM array and a registered head stage, valid/ready on both sides.
// Push to empty shows on rdata next cycle; wready depends only on registered count.
module fifo_1r1w_sync_read #(
  parameter int DATA_WIDTH = 64,
  parameter int DATA_DEPTH = 16,
  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH),
  localparam int CNT_WIDTH  = $clog2(DATA_DEPTH + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [CNT_WIDTH-1:0]  count
);

  localparam logic [CNT_WIDTH-1:0]  FULL_CNT = CNT_WIDTH'(DATA_DEPTH + 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   ACNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   acnt;

  logic push;
  logic pop;
  logic load;
  logic bypass;
  logic refill;
  logic ram_wr;

  always_comb begin
    wready = (count != FULL_CNT);
    push   = wvalid & wready;
    pop    = rvalid & rready;
    load   = !rvalid | pop;
    bypass = load & (acnt == '0) & push;
    refill = load & (acnt != '0);
    // Anything not going straight to the head stage lands in the array.
    ram_wr = push & !bypass;
  end

  // Array has no reset so it maps onto simple dual-port block RAM.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      acnt   <= '0;
      count  <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      if (ram_wr) begin
        wptr <= wptr + PTR_ONE;
      end

      // refill needs acnt>0, so it never reads the slot written this cycle
      if (refill) begin
        rdata <= mem[rptr];
        rptr  <= rptr + PTR_ONE;
      end else if (bypass) begin
        rdata <= wdata;
      end

      if (load) begin
        rvalid <= refill | bypass;
      end

      case ({ram_wr, refill})
        2'b10:   acnt <= acnt + ACNT_ONE;
        2'b01:   acnt <= acnt - ACNT_ONE;
        default: acnt <= acnt;
      endcase

      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_1r1w_sync_read.sv
// Randomised and directed bench for fifo_1r1w_sync_read against a queue model of the FIFO.
module tb_fifo_1r1w_sync_read;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int CAP   = DEPTH + 1;
  localparam int CW    = $clog2(DEPTH + 2);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [DW-1:0] wdata = '0;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [DW-1:0] rdata;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  fifo_1r1w_sync_read #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .wvalid (wvalid),
    .wready (wready),
    .wdata  (wdata),
    .rvalid (rvalid),
    .rready (rready),
    .rdata  (rdata),
    .count  (count)
  );

  always #5 clk = ~clk;

  // Reference model: contents in order, plus the last value handed out.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_last = '0;
  bit            chk_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_last = '0;
    end else begin
      automatic bit pu = wvalid && (m_q.size() != CAP);
      automatic bit po = rready && (m_q.size() > 0);
      if (po) m_last = m_q.pop_front();
      if (pu) m_q.push_back(wdata);
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      automatic int n = m_q.size();
      chk("m_rvalid", DW'(rvalid), DW'(n > 0));
      chk("m_count",  DW'(count),  DW'(n));
      chk("m_wready", DW'(wready), DW'(n != CAP));
      chk("m_rdata",  rdata, (n > 0) ? m_q[0] : m_last);
    end
  end

  // Inputs change on the falling edge, half a cycle clear of the sampling edge.
  task automatic cyc(input bit wv, input logic [DW-1:0] wd, input bit rr);
    @(negedge clk);
    wvalid = wv;
    wdata  = wd;
    rready = rr;
  endtask

  task automatic drain_empty();
    for (int k = 0; k < 4 * CAP && m_q.size() > 0; k++) cyc(0, '0, 1);
    cyc(0, '0, 0);
    chk("drain_done", DW'(count), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed;
    int cycles;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // 1: reset state, single push, hold
    @(negedge clk);
    chk("rst_rvalid", DW'(rvalid), '0);
    chk("rst_count",  DW'(count),  '0);
    chk("rst_wready", DW'(wready), 1);
    chk("rst_rdata",  rdata,       '0);
    chk_en = 1'b1;
    cyc(1, 'h11, 0);
    cyc(0, '0, 0);
    chk("t1_rvalid", DW'(rvalid), 1);
    chk("t1_rdata",  rdata,       'h11);
    chk("t1_count",  DW'(count),  1);
    repeat (5) cyc(0, '0, 0);
    chk("t1_hold", rdata, 'h11);
    drain_empty();
    chk("t1_drain_hold", rdata, 'h11);

    // 2: fill to capacity, refused push, pop reopens
    for (int i = 0; i < CAP; i++) cyc(1, DW'(i), 0);
    cyc(1, 'h99, 0);
    chk("t2_count",  DW'(count),  CAP);
    chk("t2_wready", DW'(wready), 0);
    cyc(0, '0, 1);
    chk("t2_refused", DW'(count), CAP);
    cyc(0, '0, 0);
    chk("t2_reopen", DW'(wready), 1);
    chk("t2_count16", DW'(count), DEPTH);
    drain_empty();

    // 3: full drain, one entry per cycle
    for (int i = 0; i < CAP; i++) cyc(1, DW'(i), 0);
    for (int i = 0; i < CAP; i++) begin
      cyc(0, '0, 1);
      chk("t3_rdata", rdata, DW'(i));
    end
    cyc(0, '0, 0);
    chk("t3_rvalid", DW'(rvalid), 0);
    chk("t3_count",  DW'(count),  0);

    // 4: streaming through the bypass path
    for (int i = 0; i < 20; i++) begin
      cyc(1, DW'(i), 1);
      if (i > 0) begin
        chk("t4_rdata", rdata, DW'(i - 1));
        chk("t4_count", DW'(count), 1);
      end
    end
    drain_empty();

    // 5: 40 pushes, random consumer, plus a fully random phase for pointer wrap
    pushed = 0;
    cycles = 0;
    while ((pushed < 40 || m_q.size() > 0) && cycles < 2000) begin
      automatic bit wv = (pushed < 40);
      automatic bit ok = wv && (m_q.size() != CAP);
      cyc(wv, {$urandom, $urandom}, bit'($urandom_range(0, 1)));
      if (ok) pushed++;
      cycles++;
    end
    cyc(0, '0, 0);
    chk("t5_pushed", DW'(pushed), 40);
    chk("t5_empty",  DW'(count),  0);
    for (int i = 0; i < 300; i++)
      cyc(bit'($urandom_range(0, 3) != 0), {$urandom, $urandom}, bit'($urandom_range(0, 1)));
    drain_empty();

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 9; i++) cyc(1, DW'('h50 + i), 0);
    cyc(0, '0, 0);
    chk("t6_count9", DW'(count), 9);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rvalid", DW'(rvalid), 0);
    chk("t6_count",  DW'(count),  0);
    chk("t6_rdata",  rdata,       0);
    #1 rst = 1'b0;
    cyc(1, 'hAB, 0);
    cyc(0, '0, 0);
    chk("t6_first",  rdata,       'hAB);
    chk("t6_count1", DW'(count),  1);
    drain_empty();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
